// File: rtl/snk_mem_pkg.sv
// snk_mem_pkg: shared types and constants for the SDRAM-side memory responders.
//   state_t        - responder burst FSM states
//   TILE_WORD_AW   - width of a tile ROM 32-bit word address
//   SDR_AW_DEFAULT - default SDRAM byte-address width
package snk_mem_pkg;
    localparam int TILE_WORD_AW   = 20;
    localparam int SDR_AW_DEFAULT = 24;
    typedef enum logic [2:0] {IDLE, ISSUE, BEAT0, BEAT1, DONE} state_t;
endpackage

// File: rtl/tile_rom_responder.sv
// tile_rom_responder: serves tile-cache ROM misses with a two-beat 16-bit SDRAM burst.
//   clk, reset          - system clock, asynchronous active-high reset
//   rom_req, rom_addr   - level request and 32-bit word address from the cache
//   rom_data, rom_valid - assembled word; valid level for the current request/address
//   sdr_req, sdr_addr   - burst request (held until sdr_ack) and byte address
//   sdr_ack             - one-cycle acceptance of sdr_req
//   sdr_data, sdr_rdy   - read beat and its strobe
module tile_rom_responder
    import snk_mem_pkg::*;
#(
    parameter int                SDR_AW    = SDR_AW_DEFAULT,
    parameter logic [SDR_AW-1:0] BASE_ADDR = '0,
    parameter bit                HI_FIRST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rom_req,
    input  logic [TILE_WORD_AW-1:0] rom_addr,
    output logic [31:0]             rom_data,
    output logic                    rom_valid,
    output logic                    sdr_req,
    output logic [SDR_AW-1:0]       sdr_addr,
    input  logic                    sdr_ack,
    input  logic [15:0]             sdr_data,
    input  logic                    sdr_rdy
);
    state_t                  r_state, w_next;
    logic [TILE_WORD_AW-1:0] r_req_addr, r_served_addr;
    logic [31:0]             r_asm, r_rom_data;
    logic [SDR_AW-1:0]       r_sdr_addr, w_byte_addr;
    logic                    r_served_ok, r_discard, r_rom_valid, r_sdr_req;
    logic                    w_new, w_stale, w_commit;

    // Address arithmetic wraps modulo 2^SDR_AW.
    assign w_byte_addr = BASE_ADDR + SDR_AW'({rom_addr, 2'b00});
    assign w_new       = rom_req & (!r_served_ok | (rom_addr != r_served_addr));
    // The request in flight no longer matches what the cache is asking for.
    assign w_stale     = !rom_req | (rom_addr != r_req_addr);
    // A stale request in the DONE cycle itself is also refused, so served_ok never
    // rises while rom_req is low and IDLE simply re-issues for a new address.
    assign w_commit    = !r_discard & !w_stale;

    assign rom_data  = r_rom_data;
    assign rom_valid = r_rom_valid;
    assign sdr_req   = r_sdr_req;
    assign sdr_addr  = r_sdr_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // sdr_rdy seen in ISSUE (even alongside sdr_ack) is ignored; beats only count from BEAT0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_new   ? ISSUE : IDLE;
            ISSUE:   w_next = sdr_ack ? BEAT0 : ISSUE;
            BEAT0:   w_next = sdr_rdy ? BEAT1 : BEAT0;
            BEAT1:   w_next = sdr_rdy ? DONE  : BEAT1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_addr    <= '0;
            r_served_addr <= '0;
            r_served_ok   <= 1'b0;
            r_discard     <= 1'b0;
            r_asm         <= '0;
            r_rom_data    <= '0;
            r_rom_valid   <= 1'b0;
            r_sdr_req     <= 1'b0;
            r_sdr_addr    <= '0;
        end else begin
            r_rom_valid <= rom_req & r_served_ok & (rom_addr == r_served_addr);
            if (!rom_req) r_served_ok <= 1'b0;
            // The burst cannot be cancelled, so a stale request only marks it for discard.
            if (r_state != IDLE && w_stale) r_discard <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_new) begin
                        r_req_addr  <= rom_addr;
                        r_sdr_addr  <= w_byte_addr;
                        r_sdr_req   <= 1'b1;
                        r_served_ok <= 1'b0;
                        r_discard   <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (sdr_ack) r_sdr_req <= 1'b0;
                end
                BEAT0: begin
                    if (sdr_rdy) r_asm <= HI_FIRST ? {sdr_data, r_asm[15:0]} : {r_asm[31:16], sdr_data};
                end
                BEAT1: begin
                    if (sdr_rdy) r_asm <= HI_FIRST ? {r_asm[31:16], sdr_data} : {sdr_data, r_asm[15:0]};
                end
                DONE: begin
                    if (w_commit) begin
                        r_rom_data    <= r_asm;
                        r_served_addr <= r_req_addr;
                        r_served_ok   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
